// File: rtl/iir_biquad_mc_if.sv
// Sample, result and coefficient-write signals of the multi-channel biquad.
// The master drives samples and coefficient writes; the slave is the filter.
interface iir_biquad_mc_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16,
  parameter int CH_W   = 1
);
  logic                     in_valid;
  logic                     in_ready;
  logic [CH_W-1:0]          in_ch;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic [CH_W-1:0]          out_ch;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_sat;
  logic                     coef_we;
  logic [2:0]               coef_addr;
  logic signed [COEF_W-1:0] coef_data;

  modport master (
    output in_valid, in_ch, in_data, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, out_ch, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_ch, in_data, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, out_ch, out_data, out_sat
  );
endinterface

// File: rtl/iir_biquad_mc.sv
// Time-multiplexed multi-channel direct-form-I biquad: one shared multiplier,
// five MAC cycles per sample, per-channel history, double-banked coefficients.
module iir_biquad_mc #(
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int FRAC_W   = 2,
  parameter int OUT_W    = 16,
  parameter int ACC_W    = 32,
  parameter int CHANNELS = 2
) (
  input logic            clk,
  input logic            rst,
  iir_biquad_mc_if.slave bus
);
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PROD_W = COEF_W + OUT_W;
  localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CHANNELS);
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << FRAC_W);

  typedef enum logic [2:0] {
    S_IDLE, S_MAC0, S_MAC1, S_MAC2, S_MAC3, S_MAC4, S_DONE
  } state_t;

  state_t state, state_nx;

  logic       accept, take, mac_en, done;
  logic [2:0] mac_idx;

  logic signed [DATA_W-1:0] x_p0;
  logic [CH_W-1:0]          ch_p0;
  logic signed [ACC_W-1:0]  acc_p1;

  logic signed [COEF_W-1:0] coef_sh  [5];
  logic signed [COEF_W-1:0] coef_act [5];
  logic signed [DATA_W-1:0] x1_h [CHANNELS];
  logic signed [DATA_W-1:0] x2_h [CHANNELS];
  logic signed [OUT_W-1:0]  y1_h [CHANNELS];
  logic signed [OUT_W-1:0]  y2_h [CHANNELS];

  logic signed [COEF_W-1:0] coef_sel;
  logic signed [OUT_W-1:0]  op_sel;
  logic                     sub_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic [OUT_W:0]           y_sat;

  function automatic logic signed [ACC_W-1:0] shift_floor(input logic signed [ACC_W-1:0] v);
    return v >>> FRAC_W;
  endfunction

  // Returns {clamped, value}; the value fits iff all bits above the sign agree with it.
  function automatic logic [OUT_W:0] sat_out(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-OUT_W:0] top;
    top = v[ACC_W-1:OUT_W-1];
    if ((&top) || (~|top))
      return {1'b0, v[OUT_W-1:0]};
    else if (v[ACC_W-1])
      return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  assign accept = bus.in_valid & bus.in_ready;
  assign take   = accept & ({1'b0, bus.in_ch} < CH_LIM);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = take ? S_MAC0 : S_IDLE;
      S_MAC0:  state_nx = S_MAC1;
      S_MAC1:  state_nx = S_MAC2;
      S_MAC2:  state_nx = S_MAC3;
      S_MAC3:  state_nx = S_MAC4;
      S_MAC4:  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    mac_en       = 1'b0;
    mac_idx      = 3'd0;
    done         = 1'b0;
    case (state)
      S_IDLE:  bus.in_ready = 1'b1;
      S_MAC0:  begin mac_en = 1'b1; mac_idx = 3'd0; end
      S_MAC1:  begin mac_en = 1'b1; mac_idx = 3'd1; end
      S_MAC2:  begin mac_en = 1'b1; mac_idx = 3'd2; end
      S_MAC3:  begin mac_en = 1'b1; mac_idx = 3'd3; end
      S_MAC4:  begin mac_en = 1'b1; mac_idx = 3'd4; end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Operand select: feed-forward taps add, feedback taps subtract.
  always_comb begin
    coef_sel = '0;
    op_sel   = '0;
    sub_sel  = 1'b0;
    case (mac_idx)
      3'd0: begin coef_sel = coef_act[0]; op_sel = OUT_W'(x_p0); end
      3'd1: begin coef_sel = coef_act[1]; op_sel = OUT_W'(x1_h[ch_p0]); end
      3'd2: begin coef_sel = coef_act[2]; op_sel = OUT_W'(x2_h[ch_p0]); end
      3'd3: begin coef_sel = coef_act[3]; op_sel = y1_h[ch_p0]; sub_sel = 1'b1; end
      3'd4: begin coef_sel = coef_act[4]; op_sel = y2_h[ch_p0]; sub_sel = 1'b1; end
      default: ;
    endcase
  end

  assign prod     = coef_sel * op_sel;
  assign prod_ext = ACC_W'(prod);
  assign y_sat    = sat_out(shift_floor(acc_p1));

  always_ff @(posedge clk) begin
    if (rst) bus.out_valid <= 1'b0;
    else     bus.out_valid <= done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        coef_sh[i]  <= (i == 0) ? COEF_ONE : '0;
        coef_act[i] <= (i == 0) ? COEF_ONE : '0;
      end
      for (int c = 0; c < CHANNELS; c++) begin
        x1_h[c] <= '0;
        x2_h[c] <= '0;
        y1_h[c] <= '0;
        y2_h[c] <= '0;
      end
      x_p0         <= '0;
      ch_p0        <= '0;
      acc_p1       <= '0;
      bus.out_data <= '0;
      bus.out_ch   <= '0;
      bus.out_sat  <= 1'b0;
    end else begin
      if (bus.coef_we) begin
        for (int i = 0; i < 5; i++)
          if (bus.coef_addr == 3'(i)) coef_sh[i] <= bus.coef_data;
      end
      // Stage p0: latch sample and freeze the coefficient bank for this sample.
      if (accept) coef_act <= coef_sh;
      if (take) begin
        x_p0   <= bus.in_data;
        ch_p0  <= bus.in_ch;
        acc_p1 <= '0;
      end
      // Stage p1: accumulate one product per MAC cycle.
      if (mac_en) acc_p1 <= sub_sel ? acc_p1 - prod_ext : acc_p1 + prod_ext;
      // Stage p2: publish the result and shift this channel's history.
      if (done) begin
        bus.out_data <= y_sat[OUT_W-1:0];
        bus.out_sat  <= y_sat[OUT_W];
        bus.out_ch   <= ch_p0;
        x2_h[ch_p0]  <= x1_h[ch_p0];
        x1_h[ch_p0]  <= x_p0;
        y2_h[ch_p0]  <= y1_h[ch_p0];
        y1_h[ch_p0]  <= y_sat[OUT_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_iir_biquad_mc.sv
// Directed bench for iir_biquad_mc: expected results are queued when a sample
// is driven and compared when out_valid appears.
module tb_iir_biquad_mc;
  localparam int CHANNELS = 3;
  localparam int CH_W     = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iir_biquad_mc_if #(.DATA_W(8), .COEF_W(8), .OUT_W(16), .CH_W(CH_W)) bus ();

  iir_biquad_mc #(
    .DATA_W(8), .COEF_W(8), .FRAC_W(2), .OUT_W(16), .ACC_W(32), .CHANNELS(CHANNELS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [CH_W-1:0]    ch;
    logic signed [15:0] data;
    logic               sat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out_data", $signed(bus.out_data), e.data);
        chk("out_ch", {30'd0, bus.out_ch}, {30'd0, e.ch});
        chk("out_sat", {31'd0, bus.out_sat}, {31'd0, e.sat});
      end
    end
  end

  task automatic expect_out(input int ch, input int data, input bit sat);
    exp_t e;
    e.ch   = CH_W'(ch);
    e.data = 16'(data);
    e.sat  = sat;
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic send(input int ch, input int data);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_ch    = CH_W'(ch);
    bus.in_data  = 8'(data);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send_with_write(input int ch, input int data, input int addr, input int val);
    wait_ready();
    bus.in_valid  = 1'b1;
    bus.in_ch     = CH_W'(ch);
    bus.in_data   = 8'(data);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 3'(addr);
    bus.coef_data = 8'(val);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
  endtask

  task automatic write_coef(input int addr, input int val);
    @(negedge clk);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 3'(addr);
    bus.coef_data = 8'(val);
    @(posedge clk);
    #1 bus.coef_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic check_quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, {31'd0, bus.out_valid}, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int prev;
    bit s;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_ch     = '0;
    bus.in_data   = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    do_reset();

    chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_out_data", $signed(bus.out_data), 0);
    chk("rst_out_ch", {30'd0, bus.out_ch}, 0);
    chk("rst_out_sat", {31'd0, bus.out_sat}, 0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 1);

    // Passthrough and latency: out_valid appears after the sixth edge.
    expect_out(0, 5, 0);
    send(0, 5);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("latency_early", {31'd0, bus.out_valid}, 0);
    end
    @(negedge clk);
    chk("latency_on_time", {31'd0, bus.out_valid}, 1);
    chk("ready_in_out_cycle", {31'd0, bus.in_ready}, 1);
    drain();

    // FIR taps all 1.0: impulse gives three ones.
    do_reset();
    write_coef(0, 4);
    write_coef(1, 4);
    write_coef(2, 4);
    expect_out(0, 1, 0); send(0, 1);
    expect_out(0, 1, 0); send(0, 0);
    expect_out(0, 1, 0); send(0, 0);
    expect_out(0, 0, 0); send(0, 0);
    drain();

    // Integrator ramp into positive saturation.
    do_reset();
    write_coef(3, -4);
    for (int k = 1; k <= 400; k++) begin
      e = 100 * k;
      s = (e > 32767);
      expect_out(0, s ? 32767 : e, s);
      send(0, 100);
    end
    drain();

    // Interleaved channels keep independent integrator state.
    do_reset();
    write_coef(3, -4);
    for (int k = 1; k <= 3; k++) begin
      expect_out(0, k, 0);  send(0, 1);
      expect_out(1, -k, 0); send(1, -1);
    end
    drain();

    // Mid-flight write is deferred; write on the accept edge is not seen.
    do_reset();
    expect_out(0, 3, 0);
    send(0, 3);
    @(negedge clk);
    @(negedge clk);
    write_coef(0, 8);
    expect_out(0, 6, 0);
    send(0, 3);
    expect_out(0, 6, 0);
    send_with_write(0, 3, 0, 4);
    expect_out(0, 3, 0);
    send(0, 3);
    drain();

    // Reset during MAC2 drops the sample and clears history.
    do_reset();
    expect_out(0, 7, 0);
    send(0, 7);
    drain();
    send(0, 5);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_quiet(10, "no_out_after_mid_reset");
    write_coef(1, 4);
    expect_out(0, 5, 0);
    send(0, 5);
    drain();

    // Out-of-range channel: consumed without output or history change.
    send(CHANNELS, 9);
    @(negedge clk);
    chk("ready_after_bad_ch", {31'd0, bus.in_ready}, 1);
    check_quiet(8, "no_out_bad_ch");
    expect_out(0, 6, 0);
    send(0, 1);
    drain();

    // Floor rounding of negative results.
    do_reset();
    write_coef(0, 1);
    expect_out(0, -2, 0); send(0, -5);
    expect_out(0, 1, 0);  send(0, 5);
    drain();

    // Growing feedback into negative saturation.
    do_reset();
    write_coef(3, -8);
    prev = 0;
    for (int k = 0; k < 10; k++) begin
      e = -128 + 2 * prev;
      s = (e < -32768);
      if (s) e = -32768;
      expect_out(0, e, s);
      prev = e;
      send(0, -128);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
